uart_tx_arbiter: RTL and testbench

- Shares one uart_tx transmitter among N_REQ byte-stream requesters (debug console, telemetry, fault reporter, ...).
- Grants are round-robin and packet-granular: a requester keeps the transmitter until it flags the last byte of its packet, or until it stalls too long.
- Drives the transmitter's data/start inputs and sequences every byte off its busy output.
- Sits between the requesters and a single uart_tx instance sharing the same clk/rst_n.

---
 rtl/uart_arb_pkg.sv | 20 ++
 rtl/rr_arbiter.sv | 46 ++++
 rtl/uart_tx_arbiter.sv | 153 +++++++++++++++
 tb/tb_uart_tx_arbiter.sv | 310 +++++++++++++++++++++++++++++++
 4 files changed

// File: rtl/uart_arb_pkg.sv
// Shared types and constants for the uart_tx arbiter.
// The HEADER state only becomes reachable when UART_ARB_HEADER_EN is defined.
package uart_arb_pkg;

    typedef enum logic [2:0] {
        ARB,
        HEADER,
        LOAD,
        WAIT_BUSY,
        WAIT_DONE
    } arb_state_t;

    localparam logic [7:0] HDR_TAG = 8'hA0;

    // Index width for n entries, never less than one bit.
    function automatic int idx_width(input int n);
        return (n <= 2) ? 1 : $clog2(n);
    endfunction

endpackage

// File: rtl/rr_arbiter.sv
// Combinational round-robin selector: the first set request at or above ptr, with wrap.
// The pointer register is owned by the parent.
module rr_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N  = 4,
    localparam int GW = idx_width(N)
) (
    input  logic [N-1:0]  req,
    input  logic [GW-1:0] ptr,
    output logic [N-1:0]  grant_oh,
    output logic [GW-1:0] grant_idx,
    output logic          any_req
);

    logic [GW-1:0] cand [N];
    logic [N-1:0]  rot;

    // cand[gi] is the requester that sits gi places after the pointer.
    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_cand
            logic [GW:0] sum;
            assign sum      = {1'b0, ptr} + (GW+1)'(gi);
            assign cand[gi] = (sum >= (GW+1)'(N)) ? GW'(sum - (GW+1)'(N)) : GW'(sum);
            assign rot[gi]  = req[cand[gi]];
        end
    endgenerate

    always_comb begin
        grant_idx = '0;
        for (int o = N - 1; o >= 0; o--) begin
            if (rot[o]) begin
                grant_idx = cand[o];
            end
        end
    end

    assign any_req = |req;

    generate
        for (genvar gi = 0; gi < N; gi++) begin : g_onehot
            assign grant_oh[gi] = any_req && (grant_idx == GW'(gi));
        end
    endgenerate

endmodule

// File: rtl/uart_tx_arbiter.sv
// Packet-granular round-robin sharing of one uart_tx among N_REQ byte streams.
// Define UART_ARB_HEADER_EN to prefix every grant with the byte HDR_TAG | grant_id.
module uart_tx_arbiter
    import uart_arb_pkg::*;
#(
    parameter  int N_REQ       = 4,
    parameter  int GAP_TIMEOUT = 1024,
    localparam int GW          = idx_width(N_REQ)
) (
    input  logic               clk,
    input  logic               rst_n,
    input  logic [N_REQ-1:0]   i_req_valid,
    input  logic [8*N_REQ-1:0] i_req_data,
    input  logic [N_REQ-1:0]   i_req_last,
    output logic [N_REQ-1:0]   o_req_ready,
    output logic [7:0]         o_tx_data,
    output logic               o_tx_start,
    input  logic               i_tx_busy,
    output logic [GW-1:0]      o_grant_id,
    output logic               o_grant_active
);

    localparam int             GAP_W    = idx_width(GAP_TIMEOUT);
    localparam bit             GAP_EN   = (GAP_TIMEOUT > 0);
    localparam logic [GAP_W-1:0] GAP_LAST = GAP_W'((GAP_TIMEOUT > 0) ? GAP_TIMEOUT - 1 : 0);

    arb_state_t       state_reg;
    logic [GW-1:0]    ptr_reg;
    logic [GW-1:0]    grant_id_reg;
    logic [N_REQ-1:0] grant_oh_reg;
    logic             grant_active_reg;
    logic             tx_start_reg;
    logic [7:0]       tx_data_reg;
    logic             last_reg;
    logic [GAP_W-1:0] gap_reg;

    logic [N_REQ-1:0] arb_oh;
    logic [GW-1:0]    arb_idx;
    logic             arb_any;

    logic [7:0]       data_masked [N_REQ];
    logic [7:0]       owner_data;
    logic             owner_valid;
    logic             owner_last;
    logic [GW-1:0]    ptr_next;

    rr_arbiter #(
        .N (N_REQ)
    ) u_rr (
        .req       (i_req_valid),
        .ptr       (ptr_reg),
        .grant_oh  (arb_oh),
        .grant_idx (arb_idx),
        .any_req   (arb_any)
    );

    // Owner's byte lane, selected through the registered one-hot grant.
    generate
        for (genvar gi = 0; gi < N_REQ; gi++) begin : g_lane
            assign data_masked[gi] = grant_oh_reg[gi] ? i_req_data[8*gi +: 8] : 8'h00;
        end
    endgenerate

    always_comb begin
        owner_data = 8'h00;
        for (int k = 0; k < N_REQ; k++) begin
            owner_data = owner_data | data_masked[k];
        end
    end

    assign owner_valid = |(i_req_valid & grant_oh_reg);
    assign owner_last  = |(i_req_last & grant_oh_reg);
    assign ptr_next    = (grant_id_reg == GW'(N_REQ - 1)) ? '0 : grant_id_reg + 1'b1;

    assign o_req_ready    = (state_reg == LOAD) ? grant_oh_reg : '0;
    assign o_tx_data      = tx_data_reg;
    assign o_tx_start     = tx_start_reg;
    assign o_grant_id     = grant_id_reg;
    assign o_grant_active = grant_active_reg;

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_reg        <= ARB;
            ptr_reg          <= '0;
            grant_id_reg     <= '0;
            grant_oh_reg     <= '0;
            grant_active_reg <= 1'b0;
            tx_start_reg     <= 1'b0;
            tx_data_reg      <= 8'h00;
            last_reg         <= 1'b0;
            gap_reg          <= '0;
        end else begin
            tx_start_reg <= 1'b0;
            case (state_reg)
                ARB: begin
                    if (arb_any) begin
                        grant_id_reg     <= arb_idx;
                        grant_oh_reg     <= arb_oh;
                        grant_active_reg <= 1'b1;
                        gap_reg          <= '0;
`ifdef UART_ARB_HEADER_EN
                        state_reg        <= HEADER;
`else
                        state_reg        <= LOAD;
`endif
                    end
                end
`ifdef UART_ARB_HEADER_EN
                HEADER: begin
                    // A header never ends the packet, so WAIT_DONE returns to LOAD.
                    tx_data_reg  <= HDR_TAG | 8'(grant_id_reg);
                    last_reg     <= 1'b0;
                    tx_start_reg <= 1'b1;
                    state_reg    <= WAIT_BUSY;
                end
`endif
                LOAD: begin
                    if (owner_valid) begin
                        tx_data_reg  <= owner_data;
                        last_reg     <= owner_last;
                        tx_start_reg <= 1'b1;
                        state_reg    <= WAIT_BUSY;
                    end else if (GAP_EN && gap_reg == GAP_LAST) begin
                        grant_active_reg <= 1'b0;
                        ptr_reg          <= ptr_next;
                        state_reg        <= ARB;
                    end else begin
                        gap_reg <= gap_reg + 1'b1;
                    end
                end
                WAIT_BUSY: begin
                    if (i_tx_busy) begin
                        state_reg <= WAIT_DONE;
                    end
                end
                WAIT_DONE: begin
                    if (!i_tx_busy) begin
                        if (last_reg) begin
                            grant_active_reg <= 1'b0;
                            ptr_reg          <= ptr_next;
                            state_reg        <= ARB;
                        end else begin
                            gap_reg   <= '0;
                            state_reg <= LOAD;
                        end
                    end
                end
                default: state_reg <= ARB;
            endcase
        end
    end

endmodule

// File: tb/tb_uart_tx_arbiter.sv
// Bench for uart_tx_arbiter with a behavioural uart_tx (40-cycle frames) and a packet-level
// round-robin reference model; honours UART_ARB_HEADER_EN when it is defined.
module tb_uart_tx_arbiter;

    localparam int N     = 4;
    localparam int GT    = 16;
    localparam int FRAME = 40;

    logic           clk = 1'b0;
    logic           rst_n = 1'b0;
    logic [N-1:0]   req_valid = '0;
    logic [8*N-1:0] req_data = '0;
    logic [N-1:0]   req_last = '0;
    logic [N-1:0]   req_ready;
    logic [7:0]     tx_data;
    logic           tx_start;
    logic           tx_busy;
    logic [1:0]     grant_id;
    logic           grant_active;

    always #5 clk = ~clk;

    uart_tx_arbiter #(
        .N_REQ       (N),
        .GAP_TIMEOUT (GT)
    ) dut (
        .clk            (clk),
        .rst_n          (rst_n),
        .i_req_valid    (req_valid),
        .i_req_data     (req_data),
        .i_req_last     (req_last),
        .o_req_ready    (req_ready),
        .o_tx_data      (tx_data),
        .o_tx_start     (tx_start),
        .i_tx_busy      (tx_busy),
        .o_grant_id     (grant_id),
        .o_grant_active (grant_active)
    );

    // Transmitter model: busy for one frame starting the cycle after a start pulse.
    int         busy_cnt;
    logic [7:0] busy_byte;
    always @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            tx_busy   <= 1'b0;
            busy_cnt  <= 0;
            busy_byte <= 8'h00;
        end else if (tx_busy) begin
            if (busy_cnt == FRAME - 1) tx_busy <= 1'b0;
            busy_cnt <= busy_cnt + 1;
        end else if (tx_start) begin
            tx_busy   <= 1'b1;
            busy_cnt  <= 0;
            busy_byte <= tx_data;
        end
    end

    logic [8:0] pq [N][$];
    logic [7:0] line_q[$];
    logic [7:0] exp_q[$];
    bit [N-1:0] stall = '0;
    logic [N-1:0] hs;
    int checks = 0, failures = 0;
    int start_count = 0, start_while_busy = 0, data_changed = 0, owner_err = 0;
    int model_ptr = 0;
    logic [N-1:0] gid_mask = '0;

    task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        assert (got === exp) else begin
            failures++;
            $error("FAIL %s observed=%0h expected=%0h", tag, got, exp);
        end
    endtask

    task automatic drive();
        for (int k = 0; k < N; k++) begin
            if (pq[k].size() > 0 && !stall[k]) begin
                req_valid[k]       = 1'b1;
                req_data[8*k +: 8] = pq[k][0][7:0];
                req_last[k]        = pq[k][0][8];
            end else begin
                req_valid[k]       = 1'b0;
                req_data[8*k +: 8] = 8'h00;
                req_last[k]        = 1'b0;
            end
        end
    endtask

    // Observe mid-cycle, then advance past the next edge and retire accepted bytes.
    task automatic cycle();
        @(negedge clk);
        hs = req_valid & req_ready;
        if (rst_n) begin
            if (tx_start) begin
                line_q.push_back(tx_data);
                start_count++;
                if (tx_busy) start_while_busy++;
            end
            if (tx_busy && tx_data !== busy_byte) data_changed++;
            if (hs != '0 && (!$onehot(hs) || hs != (N'(1) << grant_id) || !grant_active)) owner_err++;
            if (grant_active) gid_mask = gid_mask | (N'(1) << grant_id);
        end
        @(posedge clk);
        #1;
        for (int k = 0; k < N; k++) begin
            if (hs[k] && pq[k].size() > 0) void'(pq[k].pop_front());
        end
        drive();
    endtask

    function automatic int pending();
        int s = 0;
        for (int k = 0; k < N; k++) s += pq[k].size();
        return s;
    endfunction

    // Whole packets in round-robin order from model_ptr; every queued packet ends in last.
    task automatic model_expect();
        logic [8:0] cp [N][$];
        logic [8:0] b;
        int  k;
        bit  found;
        exp_q.delete();
        for (int i = 0; i < N; i++) cp[i] = pq[i];
        while (1) begin
            found = 0;
            k = 0;
            for (int o = 0; o < N && !found; o++) begin
                k = (model_ptr + o) % N;
                if (cp[k].size() > 0) found = 1;
            end
            if (!found) break;
`ifdef UART_ARB_HEADER_EN
            exp_q.push_back(8'hA0 | 8'(k));
`endif
            do begin
                b = cp[k].pop_front();
                exp_q.push_back(b[7:0]);
            end while (!b[8]);
            model_ptr = (k + 1) % N;
        end
    endtask

    task automatic run_until_idle(input string tag, input int maxc);
        int n = 0;
        bit done = 0;
        while (!done && n < maxc) begin
            cycle();
            n++;
            done = (pending() == 0) && !grant_active && !tx_busy && !tx_start;
        end
        check({tag, "_done"}, 32'(done), 32'd1);
    endtask

    task automatic compare_line(input string tag);
        logic [31:0] got;
        check({tag, "_count"}, line_q.size(), exp_q.size());
        for (int i = 0; i < exp_q.size(); i++) begin
            got = (i < line_q.size()) ? 32'(line_q[i]) : 32'hFFFF_FFFF;
            check($sformatf("%s_b%0d", tag, i), got, 32'(exp_q[i]));
        end
        line_q.delete();
    endtask

    initial begin
        int n;
        int npk, len;

        drive();
        repeat (3) cycle();
        check("rst_tx_data", tx_data, 0);
        check("rst_tx_start", tx_start, 0);
        check("rst_grant_id", grant_id, 0);
        check("rst_grant_active", grant_active, 0);
        check("rst_req_ready", req_ready, 0);
        rst_n = 1'b1;
        cycle();

        // Requester 1 two-byte packet
        pq[1].push_back(9'h055);
        pq[1].push_back(9'h1AA);
        model_expect();
        start_count = 0;
        gid_mask = '0;
        drive();
        run_until_idle("t1", 400);
        check("t1_starts", start_count, exp_q.size());
        check("t1_grant_ids", gid_mask, 4'b0010);
        compare_line("t1");

        // Requesters 0 and 2 from a common start, twice (second round wraps the pointer)
        pq[0].push_back(9'h111);
        pq[2].push_back(9'h122);
        model_expect();
        drive();
        run_until_idle("t2a", 400);
        compare_line("t2a");
        pq[0].push_back(9'h133);
        pq[2].push_back(9'h144);
        model_expect();
        drive();
        run_until_idle("t2b", 400);
        compare_line("t2b");

        // Requester 3 owns the line and stalls mid-packet while requester 0 waits
        pq[3].push_back(9'h031);
        pq[3].push_back(9'h032);
        pq[3].push_back(9'h133);
        pq[0].push_back(9'h1E0);
        model_expect();
        drive();
        n = 0;
        while (pq[3].size() == 3 && n < 300) begin cycle(); n++; end
        stall[3] = 1'b1;
        drive();
        n = 0;
        while (!req_ready[3] && n < 300) begin cycle(); n++; end
        repeat (5) cycle();
        check("t3_stall_owner", grant_id, 3);
        check("t3_no_steal", req_ready, 4'b1000);
        stall[3] = 1'b0;
        drive();
        run_until_idle("t3", 600);
        compare_line("t3");

        // Timeout: requester 1 sends a byte without last and goes quiet
        pq[1].push_back(9'h010);
        pq[2].push_back(9'h120);
        drive();
        n = 0;
        while (pq[1].size() != 0 && n < 300) begin cycle(); n++; end
        n = 0;
        while (!tx_busy && n < 20) begin cycle(); n++; end
        n = 0;
        while (tx_busy && n < 100) begin cycle(); n++; end
        // Busy is seen low one edge before LOAD is re-entered, hence GT+1.
        n = 0;
        while (grant_active && n < 100) begin cycle(); n++; end
        check("t4_timeout_cycles", n, GT + 1);
        run_until_idle("t4", 400);
        exp_q.delete();
`ifdef UART_ARB_HEADER_EN
        exp_q.push_back(8'hA1);
`endif
        exp_q.push_back(8'h10);
`ifdef UART_ARB_HEADER_EN
        exp_q.push_back(8'hA2);
`endif
        exp_q.push_back(8'h20);
        compare_line("t4");
        model_ptr = 3;

        // Random packet mixes
        for (int r = 0; r < 4; r++) begin
            for (int k = 0; k < N; k++) begin
                npk = $urandom_range(0, 2);
                for (int p = 0; p < npk; p++) begin
                    len = $urandom_range(1, 3);
                    for (int b = 0; b < len; b++) begin
                        pq[k].push_back({(b == len - 1), 8'($urandom_range(0, 255))});
                    end
                end
            end
            model_expect();
            drive();
            run_until_idle($sformatf("rnd%0d", r), 3000);
            compare_line($sformatf("rnd%0d", r));
        end

        // Reset ten cycles into a frame
        pq[1].push_back(9'h15A);
        drive();
        n = 0;
        while (!tx_busy && n < 100) begin cycle(); n++; end
        repeat (10) cycle();
        rst_n = 1'b0;
        #1;
        check("rst_mid_start", tx_start, 0);
        check("rst_mid_active", grant_active, 0);
        check("rst_mid_busy", tx_busy, 0);
        pq[1].delete();
        drive();
        line_q.delete();
        repeat (3) cycle();
        rst_n = 1'b1;
        repeat (2) cycle();
        check("rst_no_start", line_q.size(), 0);
        model_ptr = 0;
        pq[2].push_back(9'h1C3);
        model_expect();
        drive();
        run_until_idle("t5", 400);
        compare_line("t5");

        check("owner_only", owner_err, 0);
        check("start_while_busy", start_while_busy, 0);
        check("data_stable", data_changed, 0);

        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #900000;
        $display("FAIL watchdog expired checks=%0d failures=%0d", checks, failures);
        $fatal(1, "watchdog");
    end

endmodule
